// File: rtl/panel_pkg.sv
// Shared front-panel switch definitions: channel indices, channel count and
// default debounce/auto-repeat settings. REPEAT mask bits follow the index map.
package panel_pkg;

    localparam int unsigned PANEL_NSW = 12;

    localparam int unsigned SW_NPRWON   = 0;
    localparam int unsigned SW_LOCK     = 1;
    localparam int unsigned SW_RESET_IN = 2;
    localparam int unsigned SW_START    = 3;
    localparam int unsigned SW_STOP     = 4;
    localparam int unsigned SW_CONT     = 5;
    localparam int unsigned SW_STEP     = 6;
    localparam int unsigned SW_INC_ADDR = 7;
    localparam int unsigned SW_DEP_MEM  = 8;
    localparam int unsigned SW_DEP_IO   = 9;
    localparam int unsigned SW_EXAM_MEM = 10;
    localparam int unsigned SW_EXAM_IO  = 11;

    localparam int unsigned PANEL_DEBOUNCE_CYCLES = 4000;

    // Auto-repeat only makes sense for single-step and address increment.
    localparam logic [PANEL_NSW-1:0] PANEL_REPEAT_MASK =
        (PANEL_NSW'(1) << SW_STEP) | (PANEL_NSW'(1) << SW_INC_ADDR);

endpackage

// File: rtl/panel_debounce_chan.sv
// One switch channel: two-flop synchroniser, stability counter, debounced level
// and press/release strobes. Auto-repeat under PANEL_DEBOUNCER_AUTOREPEAT_EN.
module panel_debounce_chan
    import panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = PANEL_DEBOUNCE_CYCLES
`ifdef PANEL_DEBOUNCER_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = 200000,
    parameter int unsigned REPEAT_PERIOD = 50000,
    parameter bit          REPEAT_EN     = 1'b0
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_db,
    output logic o_press,
    output logic o_release,
    output logic o_press_nxt_c
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic             r_press;
    logic             r_release;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;
    logic             w_rpt_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Any sample matching the current level restarts the stability count.
    always_comb begin
        w_accept  = 1'b0;
        w_cnt_nxt = '0;
        if (r_s2 != r_db) begin
            if (r_cnt == CNT_LAST) begin
                w_accept = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_press_nxt_c = (w_accept & ~r_s2) | w_rpt_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_db      <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_press   <= o_press_nxt_c;
            r_release <= w_accept & r_s2;
            if (w_accept) begin
                r_db <= r_s2;
            end
        end
    end

`ifdef PANEL_DEBOUNCER_AUTOREPEAT_EN
    if (REPEAT_EN) begin : g_rpt
        localparam int unsigned RPT_MAX =
            (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int unsigned RPT_W = $clog2(RPT_MAX + 1);

        logic [RPT_W-1:0] r_rpt_cnt;
        logic             r_rpt_first;
        logic [RPT_W-1:0] w_rpt_limit;

        // First repeat waits the long delay, later ones the shorter period.
        assign w_rpt_limit = r_rpt_first ? RPT_W'(REPEAT_DELAY - 1)
                                         : RPT_W'(REPEAT_PERIOD - 1);
        assign w_rpt_fire  = ~r_db & ~w_accept & (r_rpt_cnt == w_rpt_limit);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_rpt_cnt   <= '0;
                r_rpt_first <= 1'b1;
            end else if (r_db || w_accept) begin
                r_rpt_cnt   <= '0;
                r_rpt_first <= 1'b1;
            end else if (w_rpt_fire) begin
                r_rpt_cnt   <= '0;
                r_rpt_first <= 1'b0;
            end else begin
                r_rpt_cnt   <= r_rpt_cnt + RPT_W'(1);
            end
        end
    end else begin : g_no_rpt
        assign w_rpt_fire = 1'b0;
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    assign o_db      = r_db;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/panel_debouncer.sv
// Front-panel switch conditioner: N independent debounce channels plus a
// registered any-press strobe. Optional auto-repeat: PANEL_DEBOUNCER_AUTOREPEAT_EN.
module panel_debouncer
    import panel_pkg::*;
#(
    parameter int unsigned  N               = PANEL_NSW,
    parameter int unsigned  DEBOUNCE_CYCLES = PANEL_DEBOUNCE_CYCLES,
    parameter int unsigned  REPEAT_DELAY    = 200000,
    parameter int unsigned  REPEAT_PERIOD   = 50000,
    parameter logic [N-1:0] REPEAT_MASK     = N'(PANEL_REPEAT_MASK)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] sw_raw,
    output logic [N-1:0] sw_db,
    output logic [N-1:0] sw_press,
    output logic [N-1:0] sw_release,
    output logic         any_press
);

    logic [N-1:0] w_press_nxt;
    logic         r_any_press;

    for (genvar i = 0; i < N; i++) begin : g_chan
        panel_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef PANEL_DEBOUNCER_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_MASK[i])
`endif
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .i_raw         (sw_raw[i]),
            .o_db          (sw_db[i]),
            .o_press       (sw_press[i]),
            .o_release     (sw_release[i]),
            .o_press_nxt_c (w_press_nxt[i])
        );
    end

    // Registered from the channels' next-press terms so it aligns with sw_press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_any_press <= 1'b0;
        end else begin
            r_any_press <= |w_press_nxt;
        end
    end

    assign any_press = r_any_press;

endmodule
